uart_rxq: RTL and testbench

- Standalone UART receiver with a 16x oversampled front end and a receive FIFO in front of the bus.
- Sits between the board uart_rx pin and any sysbus consumer (command parser, memory loader).
- Replaces the single-byte holding register with buffered, error-flagged reception.
- Handshake matches the existing uart block's re/rxavail style, so consumers can be swapped.

---
 rtl/uart_rxq_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_rxq.sv | 187 ++++++++++++++++++
 tb/tb_uart_rxq.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rxq_pkg.sv
// uart_rxq_pkg: shared types and constants for the buffered UART receiver.
//   uart_state_t : receive FSM states
//   OSR          : oversampling ratio (ticks per bit)
//   SAMPLE_MID   : centre tick of the three-sample majority window
//   maj3()       : 2-of-3 majority vote
package uart_rxq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    localparam int OSR        = 16;
    localparam int SAMPLE_MID = 8;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular FIFO with show-ahead output.
//   clk, rst_ : clock, asynchronous active-low reset
//   we, din   : write strobe and data (ignored when full unless a pop happens too)
//   re        : read strobe (ignored when empty)
//   dout      : head entry; holds the last popped value while empty
//   full      : no free entry
//   empty     : no valid entry
//   count     : occupancy, wptr - rptr
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     we,
    input  logic [WIDTH-1:0]         din,
    input  logic                     re,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = re && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is allowed then.
    assign do_push = we && (!full || do_pop);
    assign count   = wptr_q - rptr_q;
    assign dout    = empty ? last_q : mem[rptr_q[AW-1:0]];

    // NOTE: storage has no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[AW-1:0]] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wptr_q <= '0;
            rptr_q <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + (AW+1)'(1);
                last_q <= mem[rptr_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/uart_rxq.sv
// uart_rxq: 8N1 UART receiver, 16x oversampled, feeding a receive FIFO.
//   clk, rst_ : system clock, asynchronous active-low reset
//   rx        : serial line (idle high, asynchronous)
//   re        : pop FIFO head when rxavail=1
//   clr       : clear sticky ferr/ovf (a same-cycle new error wins)
//   dout      : FIFO head byte (show-ahead)
//   rxavail   : FIFO not empty
//   count     : FIFO occupancy
//   ferr      : sticky framing error
//   ovf       : sticky overflow (received byte dropped)
module uart_rxq
    import uart_rxq_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   rx,
    input  logic                   re,
    input  logic                   clr,
    output logic [7:0]             dout,
    output logic                   rxavail,
    output logic [$clog2(DEPTH):0] count,
    output logic                   ferr,
    output logic                   ovf
);

    // Rounded clocks per oversample tick.
    localparam int DIV   = (CLK_HZ + (BAUD * OSR) / 2) / (BAUD * OSR);
    localparam int DIV_W = $clog2(DIV + 1);

    localparam logic [3:0] S_LO    = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] S_MID   = 4'(SAMPLE_MID);
    localparam logic [3:0] S_HI    = 4'(SAMPLE_MID + 1);
    localparam logic [3:0] BIT_END = 4'(OSR - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    uart_state_t      state_q;
    uart_state_t      state_d;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       os_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shreg_q;
    logic [2:0]       samp_q;
    logic             tick;
    logic             vote_end;
    logic             vote_mid;
    logic             byte_push;
    logic             ferr_set;
    logic             ovf_set;
    logic             fifo_full;
    logic             fifo_empty;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Tick divider is parked in IDLE so the bit phase starts at the falling edge.
    assign tick = (state_q != IDLE) && (div_q == DIV_W'(DIV - 1));

    assign vote_end = maj3(samp_q);
    // The stop bit is decided on the third sample tick itself, so the live line
    // value stands in for the not-yet-registered third sample.
    assign vote_mid = maj3({rx_sync_q, samp_q[1:0]});

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        byte_push = 1'b0;
        ferr_set  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick && os_q == BIT_END) begin
                    state_d = vote_end ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && os_q == BIT_END && bit_idx_q == 3'd7) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick && os_q == S_HI) begin
                    if (vote_mid) begin
                        byte_push = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rx_sync_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Oversampling counters, sample capture and data shifter.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            div_q     <= '0;
            os_q      <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            samp_q    <= '0;
        end else if (state_q == IDLE) begin
            div_q <= '0;
            os_q  <= '0;
        end else begin
            div_q <= tick ? '0 : div_q + DIV_W'(1);
            if (state_q == START) begin
                bit_idx_q <= '0;
            end
            if (tick) begin
                os_q <= os_q + 4'd1;
                if (os_q == S_LO)  samp_q[0] <= rx_sync_q;
                if (os_q == S_MID) samp_q[1] <= rx_sync_q;
                if (os_q == S_HI)  samp_q[2] <= rx_sync_q;
                if (state_q == DATA && os_q == BIT_END) begin
                    shreg_q   <= {vote_end, shreg_q[7:1]};
                    bit_idx_q <= bit_idx_q + 3'd1;
                end
            end
        end
    end

    // A push into a full FIFO is only lost when no pop frees a slot that cycle.
    assign ovf_set = byte_push && fifo_full && !re;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ferr <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            if (ferr_set)  ferr <= 1'b1;
            else if (clr)  ferr <= 1'b0;
            if (ovf_set)   ovf  <= 1'b1;
            else if (clr)  ovf  <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .we    (byte_push),
        .din   (shreg_q),
        .re    (re),
        .dout  (dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    assign rxavail = !fifo_empty;

endmodule

// File: tb/tb_uart_rxq.sv
// tb_uart_rxq: directed self-checking bench for uart_rxq with a byte scoreboard.
// Runs at a reduced clock/baud ratio (4 clocks per tick, 64 per bit) to keep frames short.
module tb_uart_rxq;

    localparam int CLK_HZ = 1_000_000;
    localparam int BAUD   = 15_625;
    localparam int DEPTH  = 8;
    localparam int DIV    = 4;
    localparam int BIT    = 64;

    logic       clk  = 1'b0;
    logic       rst_ = 1'b0;
    logic       rx   = 1'b1;
    logic       re   = 1'b0;
    logic       clr  = 1'b0;
    logic [7:0] dout;
    logic       rxavail;
    logic [3:0] count;
    logic       ferr;
    logic       ovf;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    int         cyc = 0;
    int         rise_cyc = -1;
    int         start_cyc = 0;
    int         ferr_rises = 0;
    logic       rxavail_prev = 1'b0;
    logic       ferr_prev = 1'b0;

    uart_rxq #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rst_    (rst_),
        .rx      (rx),
        .re      (re),
        .clr     (clr),
        .dout    (dout),
        .rxavail (rxavail),
        .count   (count),
        .ferr    (ferr),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Edge monitors, sampled away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rxavail && !rxavail_prev) rise_cyc = cyc;
        rxavail_prev = rxavail;
        if (ferr && !ferr_prev) ferr_rises = ferr_rises + 1;
        ferr_prev = ferr;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        cycles(BIT);
    endtask

    task automatic model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    // Full 8N1 frame; the line is left at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok = 1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (stop_ok) model_push(b);
    endtask

    task automatic read_check(input string tag);
        logic [7:0] e;
        @(negedge clk);
        check({tag, "_avail"}, {31'd0, rxavail}, 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        check(tag, {24'd0, dout}, {24'd0, e});
        @(posedge clk);
        re = 1'b1;
        @(posedge clk);
        re = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        clr = 1'b1;
        @(posedge clk);
        clr = 1'b0;
    endtask

    initial begin
        // Reset state
        cycles(5);
        @(negedge clk);
        check("rst_dout", {24'd0, dout}, 32'h00);
        check("rst_rxavail", {31'd0, rxavail}, 32'd0);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk);
        rst_ = 1'b1;
        cycles(10);

        // Single byte and its arrival latency
        start_cyc = cyc;
        send_byte(8'hA5);
        cycles(3);
        @(negedge clk);
        check("a5_latency_in_window",
              {31'd0, ((rise_cyc - start_cyc) >= 9 * BIT) && ((rise_cyc - start_cyc) <= 10 * BIT + 2)}, 32'd1);
        check("a5_dout", {24'd0, dout}, 32'hA5);
        check("a5_count", {28'd0, count}, 32'd1);
        read_check("a5_read");
        @(negedge clk);
        check("a5_empty_avail", {31'd0, rxavail}, 32'd0);
        check("a5_empty_count", {28'd0, count}, 32'd0);

        // Back-to-back frames, no idle gap
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h55);
        cycles(4);
        @(negedge clk);
        check("b2b_count", {28'd0, count}, 32'd3);
        read_check("b2b_rd0");
        read_check("b2b_rd1");
        read_check("b2b_rd2");
        @(negedge clk);
        check("b2b_ferr", {31'd0, ferr}, 32'd0);
        check("b2b_ovf", {31'd0, ovf}, 32'd0);

        // Overflow: nine bytes into eight entries
        for (int b = 1; b <= 9; b++) send_byte(8'(b));
        cycles(4);
        @(negedge clk);
        check("ovf_count_full", {28'd0, count}, 32'd8);
        check("ovf_flag", {31'd0, ovf}, {31'd0, exp_ovf});
        for (int i = 0; i < 8; i++) read_check("ovf_read");
        @(negedge clk);
        check("ovf_drained_avail", {31'd0, rxavail}, 32'd0);
        check("ovf_dout_holds_last", {24'd0, dout}, 32'h08);
        @(posedge clk);
        re = 1'b1;
        @(posedge clk);
        re = 1'b0;
        @(negedge clk);
        check("empty_re_count", {28'd0, count}, 32'd0);
        check("empty_re_ovf_kept", {31'd0, ovf}, 32'd1);
        pulse_clr();
        exp_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", {31'd0, ovf}, {31'd0, exp_ovf});

        // Framing error, long break, then recovery
        send_byte(8'h3C, 1'b0);
        cycles(30 * BIT);
        rx = 1'b1;
        cycles(BIT);
        @(negedge clk);
        check("ferr_set", {31'd0, ferr}, 32'd1);
        check("ferr_once", ferr_rises, 32'd1);
        check("ferr_no_push", {28'd0, count}, 32'd0);
        send_byte(8'h7E);
        cycles(4);
        read_check("after_break");
        pulse_clr();
        @(negedge clk);
        check("ferr_cleared", {31'd0, ferr}, 32'd0);

        // Short low glitch on an idle line
        @(posedge clk);
        rx = 1'b0;
        cycles(19);
        rx = 1'b1;
        cycles(2 * BIT);
        @(negedge clk);
        check("glitch_count", {28'd0, count}, 32'd0);
        check("glitch_ferr", {31'd0, ferr}, 32'd0);
        check("glitch_ovf", {31'd0, ovf}, 32'd0);

        // 0x00 with a DIV-wide high spike in bit 3: covers exactly one sample tick
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);
        rx = 1'b0;
        cycles(34);
        rx = 1'b1;
        cycles(DIV);
        rx = 1'b0;
        cycles(BIT - 34 - DIV);
        for (int i = 4; i < 8; i++) drive_bit(1'b0);
        drive_bit(1'b1);
        model_push(8'h00);
        cycles(4);
        @(negedge clk);
        check("spike_count", {28'd0, count}, 32'd1);
        read_check("spike_read");

        // Reset in the middle of bit 4
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        cycles(BIT / 2);
        rst_ = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        cycles(3);
        @(posedge clk);
        rst_ = 1'b1;
        cycles(2 * BIT);
        @(negedge clk);
        check("midrst_count", {28'd0, count}, 32'd0);
        check("midrst_ferr", {31'd0, ferr}, 32'd0);
        send_byte(8'h81);
        cycles(4);
        @(negedge clk);
        check("midrst_new_count", {28'd0, count}, 32'd1);
        check("midrst_new_dout", {24'd0, dout}, 32'h81);
        read_check("midrst_read");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
